imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encodings and default memory geometry, used by the RTL and its bench.
package imem_loader_pkg;

    localparam int MEM_BYTES_DEF = 32;
    localparam int ADDR_W_DEF    = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream (LEN, 4N payload bytes, XOR CHK),
// writes the payload big-endian into instruction memory from address 0 and
// releases the core via cpu_run once the checksum verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              load_err,
    output logic              busy,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [7:0]      MAX_WORDS = 8'(MEM_BYTES / 4);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

    state_t          state, state_nxt;
    logic            accept;
    logic            len_bad;
    logic            last_byte;
    logic            chk_ok;
    logic            wr_fire;
    logic            len_take;
    logic [ADDR_W:0] total_bytes;
    logic [7:0]      chk_acc;

    assign accept    = in_valid && in_ready;
    assign len_bad   = (in_data == 8'd0) || (in_data > MAX_WORDS);
    assign last_byte = (byte_count == total_bytes - ONE);
    assign chk_ok    = (in_data == chk_acc);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LEN;
            end
            LEN: begin
                if (accept) state_nxt = len_bad ? ERROR : LOAD;
            end
            LOAD: begin
                if (accept && last_byte) state_nxt = CHECK;
            end
            CHECK: begin
                if (accept) state_nxt = chk_ok ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (start) state_nxt = LEN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from current state
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        wr_fire  = 1'b0;
        len_take = 1'b0;
        unique case (state)
            LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                len_take = in_valid && !len_bad;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                wr_fire  = in_valid;
            end
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: registered memory write port, address/count, checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'd0;
            byte_count  <= '0;
            total_bytes <= '0;
            chk_acc     <= 8'd0;
            cpu_run     <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            mem_we   <= wr_fire;
            cpu_run  <= (state_nxt == DONE);
            load_err <= (state_nxt == ERROR);
            if (len_take) begin
                // N <= MEM_BYTES/4 here, so 4N fits in ADDR_W+1 bits
                total_bytes <= {in_data[ADDR_W-2:0], 2'b00};
                byte_count  <= '0;
                chk_acc     <= 8'd0;
            end
            if (wr_fire) begin
                mem_addr   <= byte_count[ADDR_W-1:0];
                mem_wdata  <= in_data;
                byte_count <= byte_count + ONE;
                chk_acc    <= chk_acc ^ in_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames are streamed in, expected memory writes are
// queued on acceptance and matched against the DUT's registered write port.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = ADDR_W_DEF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_run;
    logic          load_err;
    logic          busy;
    logic [AW:0]   byte_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        time           t;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(.MEM_BYTES(MEM_BYTES_DEF), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .load_err(load_err), .busy(busy),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor: every write must match the next queued byte, presented
    // exactly one cycle (half-period at this negedge) after its acceptance.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%0d data=%02h, required no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || $time != e.t + 5) begin
                    n_fail++;
                    $display("FAIL write: addr=%0d data=%02h t=%0t, required addr=%0d data=%02h t=%0t",
                             mem_addr, mem_wdata, $time, e.addr, e.data, e.t + 5);
                end
            end
        end
    end

    // Drive one byte and hold it until accepted; payload bytes are queued.
    task automatic send_byte(input logic [7:0] b, input bit payload, input int addr);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: byte %02h not accepted, required acceptance", b);
        end else if (payload) begin
            exp_q.push_back('{AW'(addr), b, $time});
        end
        #1;
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Start pulse with a decoy byte offered; it must not be accepted.
    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ready: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_run !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL len_state: ready=%b busy=%b run=%b err=%b, required 1 1 0 0",
                     in_ready, busy, cpu_run, load_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name, input logic run, input logic err,
                                input logic [AW:0] bc);
        @(negedge clk);
        n_checks++;
        if (cpu_run !== run || load_err !== err || busy !== 1'b0 || in_ready !== 1'b0 ||
            byte_count !== bc || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: run=%b err=%b busy=%b ready=%b count=%0d pending=%0d, required run=%b err=%b busy=0 ready=0 count=%0d pending=0",
                     name, cpu_run, load_err, busy, in_ready, byte_count, exp_q.size(), run, err, bc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input logic [7:0] chk, input int gap);
        send_byte(8'(bytes.size() / 4), 1'b0, 0);
        foreach (bytes[i]) begin
            send_byte(bytes[i], 1'b1, i);
            if (gap > 0 && (i % 2 == 0)) idle_cycles(gap);
        end
        send_byte(chk, 1'b0, 0);
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 8'd0 ||
            cpu_run !== 1'b0 || load_err !== 1'b0 || busy !== 1'b0 || byte_count !== '0 ||
            dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL %s: ready=%b we=%b addr=%0d wdata=%02h run=%b err=%b busy=%b count=%0d state=%0d, required all 0 and IDLE",
                     name, in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy, byte_count, dut.state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_good_one_word();
        logic [7:0] p[$] = '{8'h8C, 8'h01, 8'h00, 8'h04};
        do_start();
        send_frame(p, 8'h89, 0);
        check_result("good_1word", 1'b1, 1'b0, (AW+1)'(4));
    endtask

    task automatic test_full_load();
        logic [7:0] p[$];
        logic [7:0] chk = 8'd0;
        for (int i = 0; i < MEM_BYTES_DEF; i++) begin
            p.push_back(8'(i));
            chk ^= 8'(i);
        end
        do_start();
        send_frame(p, chk, 0);
        check_result("full_load", 1'b1, 1'b0, (AW+1)'(MEM_BYTES_DEF));
    endtask

    task automatic test_bad_len(input logic [7:0] n);
        do_start();
        send_byte(n, 1'b0, 0);
        check_result($sformatf("bad_len_%0d", n), 1'b0, 1'b1, (AW+1)'(32));
    endtask

    task automatic test_bad_chk();
        logic [7:0] p[$] = '{8'h8C, 8'h01, 8'h00, 8'h04};
        do_start();
        send_frame(p, 8'h88, 0);
        check_result("bad_chk", 1'b0, 1'b1, (AW+1)'(4));
        do_start();
        send_frame(p, 8'h89, 0);
        check_result("after_bad_chk", 1'b1, 1'b0, (AW+1)'(4));
    endtask

    task automatic test_backpressure();
        logic [7:0] p[$];
        logic [7:0] chk = 8'd0;
        for (int i = 0; i < 8; i++) begin
            p.push_back(8'($urandom));
            chk ^= p[i];
        end
        do_start();
        send_frame(p, chk, 2);
        check_result("backpressure", 1'b1, 1'b0, (AW+1)'(8));
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] p[$] = '{8'h8C, 8'h01, 8'h00, 8'h04};
        do_start();
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h34, 1'b1, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_mid_load");
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_pending: pending=%0d, required 0", exp_q.size());
        end
        do_start();
        send_frame(p, 8'h89, 0);
        check_result("reload_after_reset", 1'b1, 1'b0, (AW+1)'(4));
    endtask

    initial begin
        test_reset();
        test_good_one_word();
        test_full_load();
        test_bad_len(8'd0);
        test_bad_len(8'd9);
        test_bad_chk();
        test_backpressure();
        test_reset_mid_load();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
